// File: rtl/cpu_bus_stim.sv
// cpu_bus_stim
//   Data-bus stimulus and opcode-fetch monitor for a CPU core bench.
//   DI carries a constant FILL byte, or a byte from a loadable pattern table
//   indexed by the low address bits. When the sled check is enabled, a small
//   checker follows sync/AD/WE to confirm that opcode fetches are strictly
//   sequential and that no write occurs. It latches the first violation.
//
// Ports
//   clk        system clock, rising edge
//   RST_n      asynchronous active-low reset
//   mode       0 = FILL, 1 = table replay, 2 = FILL + sled check, 3 = FILL
//   cfg_we     table write strobe
//   cfg_addr   table write index
//   cfg_data   table write data
//   AD         cpu address bus
//   WE         cpu write enable (1 = write)
//   sync       cpu opcode-fetch cycle marker
//   DI         data to cpu (combinational)
//   fetch_cnt  saturating count of sync cycles since reset or mode change
//   armed      checker holds a reference fetch address
//   err        sticky violation flag
//   err_code   01 = non-sequential fetch, 10 = write during sled, 00 = none
//   err_addr   AD at the offending cycle
module cpu_bus_stim #(
  parameter int              AW    = 16,
  parameter int              DW    = 8,
  parameter int              DEPTH = 16,
  parameter logic [DW-1:0]   FILL  = 8'hEA,
  parameter int              CNT_W = 16,
  localparam int             IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic [1:0]       mode,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_addr,
  input  logic [DW-1:0]    cfg_data,
  input  logic [AW-1:0]    AD,
  input  logic             WE,
  input  logic             sync,
  output logic [DW-1:0]    DI,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             armed,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [AW-1:0]    err_addr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DW-1:0] tbl_reg [DEPTH];
  state_t        state_reg;
  logic [AW-1:0] prev_ad_reg;
  logic [1:0]    mode_prev_reg;
  // No previous mode exists on the first edge after reset. Without this flag,
  // that edge would look like a mode change and would drop the first fetch.
  logic          mode_vld_reg;
  logic          mode_chg;

  // The table read is combinational, so the CPU sees its data in the same cycle.
  // A write to the same entry shows on DI one cycle later.
  always_comb begin
    DI = FILL;
    if (mode == 2'd1) DI = tbl_reg[AD[IW-1:0]];
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_reg[i] <= FILL;
    end else if (cfg_we) begin
      tbl_reg[cfg_addr] <= cfg_data;
    end
  end

  assign mode_chg = mode_vld_reg && (mode != mode_prev_reg);
  assign armed    = (state_reg != IDLE);

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      mode_prev_reg <= 2'd0;
      mode_vld_reg  <= 1'b0;
      fetch_cnt     <= '0;
      state_reg     <= IDLE;
      prev_ad_reg   <= '0;
      err           <= 1'b0;
      err_code      <= 2'b00;
      err_addr      <= '0;
    end else begin
      mode_prev_reg <= mode;
      mode_vld_reg  <= 1'b1;
      if (mode_chg) begin
        // A mode change restarts monitoring. The sync seen in this cycle is discarded.
        fetch_cnt   <= '0;
        state_reg   <= IDLE;
        prev_ad_reg <= '0;
        err         <= 1'b0;
        err_code    <= 2'b00;
        err_addr    <= '0;
      end else begin
        if (sync && (fetch_cnt != CNT_MAX)) fetch_cnt <= fetch_cnt + 1'b1;
        if (mode == 2'd2) begin
          case (state_reg)
            IDLE: begin
              // The first fetch only sets the reference. Writes made during the
              // reset-vector sequence are ignored here.
              if (sync) begin
                prev_ad_reg <= AD;
                state_reg   <= RUN;
              end
            end
            RUN: begin
              // If a write and a bad fetch occur in the same cycle, the write is reported.
              if (WE) begin
                err       <= 1'b1;
                err_code  <= 2'b10;
                err_addr  <= AD;
                state_reg <= ERR;
              end else if (sync) begin
                // The addition is done at AW bits, so all-ones followed by zero is sequential.
                if (AD != prev_ad_reg + AW'(1)) begin
                  err       <= 1'b1;
                  err_code  <= 2'b01;
                  err_addr  <= AD;
                  state_reg <= ERR;
                end else begin
                  prev_ad_reg <= AD;
                end
              end
            end
            ERR:     state_reg <= ERR;
            default: state_reg <= IDLE;
          endcase
        end else begin
          state_reg <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_stim.sv
// Directed bench for cpu_bus_stim. Instance dut uses the default parameters.
// Instance dut4 uses CNT_W=4 and is used only for the saturation check.
module tb_cpu_bus_stim;

  logic        clk;
  logic        RST_n;
  logic [1:0]  mode;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [15:0] AD;
  logic        WE;
  logic        sync;

  logic [7:0]  DI, DI4;
  logic [15:0] fetch_cnt;
  logic [3:0]  fetch_cnt4;
  logic        armed, armed4, err, err4;
  logic [1:0]  err_code, err_code4;
  logic [15:0] err_addr, err_addr4;

  int n_checks = 0;
  int n_err    = 0;

  cpu_bus_stim dut (
    .clk(clk), .RST_n(RST_n), .mode(mode), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .AD(AD), .WE(WE), .sync(sync), .DI(DI),
    .fetch_cnt(fetch_cnt), .armed(armed), .err(err), .err_code(err_code),
    .err_addr(err_addr)
  );

  cpu_bus_stim #(.CNT_W(4)) dut4 (
    .clk(clk), .RST_n(RST_n), .mode(mode), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .AD(AD), .WE(WE), .sync(sync), .DI(DI4),
    .fetch_cnt(fetch_cnt4), .armed(armed4), .err(err4), .err_code(err_code4),
    .err_addr(err_addr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    RST_n = 1'b0; mode = 2'd2; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    AD = 16'h0000; WE = 1'b0; sync = 1'b0;
    #12;
    check("rst_fetch_cnt", fetch_cnt, 0);
    check("rst_armed", armed, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_di_fill", DI, 8'hEA);
    @(negedge clk);
    RST_n = 1'b1;

    // 1: EA sled, 100 sequential fetches starting at EAEA
    for (int i = 0; i < 100; i++) begin
      sync = 1'b1; AD = 16'hEAEA + 16'(i);
      tick();
    end
    sync = 1'b0;
    check("t1_fetch_cnt", fetch_cnt, 100);
    check("t1_err", err, 0);
    check("t1_armed", armed, 1);
    check("t1_di", DI, 8'hEA);
    $display("t1 sled: fetch_cnt=%0d err=%0b armed=%0b", fetch_cnt, err, armed);

    // 2: wrap-around is legal, the following skip is flagged
    mode = 2'd0; tick();
    check("t2_clr_cnt", fetch_cnt, 0);
    check("t2_clr_armed", armed, 0);
    mode = 2'd2; tick();
    sync = 1'b1; AD = 16'hFFFF; tick();
    check("t2_armed", armed, 1);
    AD = 16'h0000; tick();
    check("t2_wrap_err", err, 0);
    AD = 16'h0002; tick();
    sync = 1'b0;
    check("t2_err", err, 1);
    check("t2_err_code", err_code, 2'b01);
    check("t2_err_addr", err_addr, 16'h0002);
    check("t2_fetch_cnt", fetch_cnt, 3);
    $display("t2 wrap: err=%0b code=%b addr=%h", err, err_code, err_addr);

    // 3: write during sled; a write while IDLE is ignored
    mode = 2'd0; tick();
    mode = 2'd2; tick();
    WE = 1'b1; AD = 16'h0123; tick();
    WE = 1'b0;
    check("t3_idle_we_err", err, 0);
    check("t3_idle_armed", armed, 0);
    sync = 1'b1; AD = 16'h0100; tick();
    sync = 1'b0; WE = 1'b1; AD = 16'h0200; tick();
    WE = 1'b0;
    check("t3_err", err, 1);
    check("t3_err_code", err_code, 2'b10);
    check("t3_err_addr", err_addr, 16'h0200);
    sync = 1'b1; AD = 16'h0300; tick();
    sync = 1'b0;
    check("t3_frozen_code", err_code, 2'b10);
    check("t3_frozen_addr", err_addr, 16'h0200);
    check("t3_cnt_runs", fetch_cnt, 2);
    // A write in the same cycle as a fetch mismatch is reported as a write
    mode = 2'd0; tick();
    mode = 2'd2; tick();
    sync = 1'b1; AD = 16'h0500; tick();
    WE = 1'b1; AD = 16'h0600; tick();
    WE = 1'b0; sync = 1'b0;
    check("t3_wins_code", err_code, 2'b10);
    check("t3_wins_addr", err_addr, 16'h0600);
    $display("t3 write: err=%0b code=%b addr=%h", err, err_code, err_addr);

    // 4: table replay
    mode = 2'd1; tick();
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 8'hA9; tick();
    cfg_addr = 4'd4; cfg_data = 8'h55; tick();
    cfg_we = 1'b0;
    AD = 16'h1233; #1; check("t4_di_3", DI, 8'hA9);
    AD = 16'h1234; #1; check("t4_di_4", DI, 8'h55);
    AD = 16'h1235; #1; check("t4_di_5", DI, 8'hEA);
    AD = 16'h1233; cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 8'h3C; #1;
    check("t4_di_old", DI, 8'hA9);
    tick();
    cfg_we = 1'b0; #1;
    check("t4_di_new", DI, 8'h3C);
    $display("t4 table: DI[3]=%h", DI);

    // 5: counter saturation and clear on mode change
    mode = 2'd2; tick();
    for (int i = 0; i < 20; i++) begin
      sync = 1'b1; AD = 16'h4000 + 16'(i);
      tick();
    end
    sync = 1'b0;
    check("t5_sat4", fetch_cnt4, 15);
    check("t5_cnt16", fetch_cnt, 20);
    mode = 2'd0; tick();
    check("t5_clr_cnt4", fetch_cnt4, 0);
    check("t5_clr_err", err, 0);
    check("t5_clr_armed", armed, 0);
    mode = 2'd1; tick();
    AD = 16'h0003; #1; check("t5_tbl_3", DI, 8'h3C);
    AD = 16'h0004; #1; check("t5_tbl_4", DI, 8'h55);
    $display("t5 sat: fetch_cnt4 saturated, table kept");

    // 6: asynchronous reset while err is set
    mode = 2'd2; tick();
    sync = 1'b1; AD = 16'h0010; tick();
    AD = 16'h0020; tick();
    sync = 1'b0;
    check("t6_pre_err", err, 1);
    #2 RST_n = 1'b0;
    #1;
    check("t6_err", err, 0);
    check("t6_code", err_code, 0);
    check("t6_addr", err_addr, 0);
    check("t6_cnt", fetch_cnt, 0);
    check("t6_armed", armed, 0);
    mode = 2'd1;
    for (int i = 0; i < 16; i++) begin
      AD = 16'(i); #1;
      check("t6_tbl_fill", DI, 8'hEA);
    end
    $display("t6 reset: outputs cleared, table refilled");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
